// File: rtl/cc_mim_pkg.sv
// Shared definitions for the microprogram sequencer: microword field offsets,
// COND encodings, sequencer states and the instruction decode-address helper.
package cc_mim_pkg;

    // Field offsets relative to the JUMP ADDR width (AW); JUMP ADDR sits at [AW-1:0].
    localparam int COND_OFS  = 0;
    localparam int COND_W    = 3;
    localparam int ALU_OFS   = 3;
    localparam int ALU_W     = 4;
    localparam int WR_OFS    = 7;
    localparam int RD_OFS    = 8;
    localparam int CTRL_W    = 9;
    localparam int DECODE_W  = 11;

    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    // Opcode-dispatch target: {1, op, op3, 00}, four microwords per instruction.
    function automatic logic [DECODE_W-1:0] decode_addr(input logic [1:0] op,
                                                        input logic [5:0] op3);
        return {1'b1, op, op3, 2'b00};
    endfunction

endpackage

// File: rtl/cc_mim_cs_ram.sv
// Writable control store: one write port and a synchronous, enable-gated read port
// whose output register doubles as the microinstruction register.
module cc_mim_cs_ram #(
    parameter int AW = 11,
    parameter int DW = 41
) (
    input  logic          clk,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [DW-1:0] write_data,
    input  logic          read_en,
    input  logic [AW-1:0] read_addr,
    output logic [DW-1:0] read_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read data is held when read_en is low so a stalled microword stays put.
    always_ff @(posedge clk) begin
        if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/cc_mim_microsequencer.sv
// Microprogram sequencer: CSAR/MIR registers, next-address selection and the
// IDLE/RUN/MEMWAIT control FSM around a loadable control store.
module cc_mim_microsequencer
    import cc_mim_pkg::*;
#(
    parameter int DATAWIDTH_MICROWORD = 41,
    parameter int DATAWIDTH_ADDRESS   = 11
) (
    input  logic                           CC_MIM_MICROSEQUENCER_CLOCK_50,
    input  logic                           CC_MIM_MICROSEQUENCER_RESET_InLow,
    input  logic                           start_In,
    input  logic                           halt_In,
    input  logic                           load_en_In,
    input  logic [DATAWIDTH_ADDRESS-1:0]   load_addr_InBUS,
    input  logic [DATAWIDTH_MICROWORD-1:0] load_data_InBUS,
    input  logic [31:0]                    ir_InBUS,
    input  logic [3:0]                     psr_nzvc_InBUS,
    input  logic                           mem_ready_In,
    output logic [DATAWIDTH_MICROWORD-1:0] mir_OutBUS,
    output logic [DATAWIDTH_ADDRESS-1:0]   csar_OutBUS,
    output logic                           busy_Out,
    output logic                           load_reject_Out
);

    localparam int AW       = DATAWIDTH_ADDRESS;
    localparam int DW       = DATAWIDTH_MICROWORD;
    localparam int COND_LSB = AW + COND_OFS;
    localparam int WR_BIT   = AW + WR_OFS;
    localparam int RD_BIT   = AW + RD_OFS;

    logic          clk;
    logic          rst_n;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [AW-1:0] csar;
    logic [AW-1:0] csar_next;
    logic [AW-1:0] csar_inc;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] mir;
    logic [2:0]    cond;
    logic          mem_op;
    logic          busy;
    logic          jump_taken;
    logic          read_en;
    logic          write_en;
    logic          load_reject;
    logic          unused_ir;

    assign clk   = CC_MIM_MICROSEQUENCER_CLOCK_50;
    assign rst_n = CC_MIM_MICROSEQUENCER_RESET_InLow;

    assign busy      = (state == ST_RUN) || (state == ST_MEMWAIT);
    assign cond      = mir[COND_LSB+COND_W-1:COND_LSB];
    assign jump_addr = mir[AW-1:0];
    assign mem_op    = mir[RD_BIT] | mir[WR_BIT];
    assign csar_inc  = csar + AW'(1);
    assign unused_ir = ^{ir_InBUS[29:25], ir_InBUS[18:14], ir_InBUS[12:0]};

    cc_mim_cs_ram #(
        .AW(AW),
        .DW(DW)
    ) u_cs_ram (
        .clk        (clk),
        .write_en   (write_en),
        .write_addr (load_addr_InBUS),
        .write_data (load_data_InBUS),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (mir)
    );

    // Next-address selector; a failed conditional jump falls through to CSAR+1.
    always_comb begin
        jump_taken = 1'b0;
        case (cond)
            COND_N:      jump_taken = psr_nzvc_InBUS[3];
            COND_Z:      jump_taken = psr_nzvc_InBUS[2];
            COND_V:      jump_taken = psr_nzvc_InBUS[1];
            COND_C:      jump_taken = psr_nzvc_InBUS[0];
            COND_IR13:   jump_taken = ir_InBUS[13];
            COND_ALWAYS: jump_taken = 1'b1;
            default:     jump_taken = 1'b0;
        endcase

        next_addr = csar_inc;
        if (cond == COND_DECODE) begin
            next_addr = AW'(decode_addr(ir_InBUS[31:30], ir_InBUS[24:19]));
        end else if (jump_taken) begin
            next_addr = jump_addr;
        end
    end

    // RUN and MEMWAIT share one rule: a pending memory access without ready
    // holds everything, otherwise halt wins over advancing.
    always_comb begin
        state_next = state;
        csar_next  = csar;
        read_en    = 1'b0;
        read_addr  = '0;
        write_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_en_In) begin
                    write_en = 1'b1;
                end else if (start_In) begin
                    read_en    = 1'b1;
                    read_addr  = '0;
                    csar_next  = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_MEMWAIT: begin
                if (mem_op && !mem_ready_In) begin
                    state_next = ST_MEMWAIT;
                end else if (halt_In) begin
                    state_next = ST_IDLE;
                    csar_next  = '0;
                end else begin
                    state_next = ST_RUN;
                    csar_next  = next_addr;
                    read_en    = 1'b1;
                    read_addr  = next_addr;
                end
            end
            default: begin
                state_next = ST_IDLE;
                csar_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            csar        <= '0;
            load_reject <= 1'b0;
        end else begin
            state       <= state_next;
            csar        <= csar_next;
            load_reject <= load_en_In && (state != ST_IDLE);
        end
    end

    // The store's read register is not reset, so MIR is masked outside execution.
    assign mir_OutBUS      = busy ? mir : '0;
    assign csar_OutBUS     = csar;
    assign busy_Out        = busy;
    assign load_reject_Out = load_reject;

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Scoreboard bench for cc_mim_microsequencer: a behavioural model predicts each
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_cc_mim_microsequencer;

    localparam int AW     = 11;
    localparam int DW     = 41;
    localparam int DEPTH  = 2048;
    localparam int RD_B   = 19;
    localparam int WR_B   = 18;
    localparam int COND_L = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          halt;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [31:0]   ir;
    logic [3:0]    psr;
    logic          mem_ready;
    logic [DW-1:0] mir;
    logic [AW-1:0] csar;
    logic          busy;
    logic          reject;

    typedef struct {
        logic          busy;
        logic [AW-1:0] csar;
        logic [DW-1:0] mir;
        logic          reject;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] cs_model [DEPTH];
    bit            m_busy;
    int            m_pc;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    cc_mim_microsequencer #(
        .DATAWIDTH_MICROWORD(DW),
        .DATAWIDTH_ADDRESS  (AW)
    ) dut (
        .CC_MIM_MICROSEQUENCER_CLOCK_50    (clk),
        .CC_MIM_MICROSEQUENCER_RESET_InLow (rst_n),
        .start_In                          (start),
        .halt_In                           (halt),
        .load_en_In                        (load_en),
        .load_addr_InBUS                   (load_addr),
        .load_data_InBUS                   (load_data),
        .ir_InBUS                          (ir),
        .psr_nzvc_InBUS                    (psr),
        .mem_ready_In                      (mem_ready),
        .mir_OutBUS                        (mir),
        .csar_OutBUS                       (csar),
        .busy_Out                          (busy),
        .load_reject_Out                   (reject)
    );

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input bit rd, input bit wr, input int cond, input int jump);
        logic [63:0]   r;
        logic [DW-1:0] w;
        r = {$urandom, $urandom};
        w = r[DW-1:0];
        w[RD_B] = rd;
        w[WR_B] = wr;
        w[COND_L+2:COND_L] = cond[2:0];
        w[AW-1:0] = jump[AW-1:0];
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return mk_word($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)));
    endfunction

    // Reference next-address rule, straight from the COND table.
    function automatic int next_pc(input logic [DW-1:0] w, input int pc);
        int cond;
        int target;
        bit take;
        cond   = int'(w[COND_L+2:COND_L]);
        target = int'(w[AW-1:0]);
        case (cond)
            1:       take = psr[3];
            2:       take = psr[2];
            3:       take = psr[1];
            4:       take = psr[0];
            5:       take = ir[13];
            6:       take = 1'b1;
            default: take = 1'b0;
        endcase
        if (cond == 7) return 1024 + 256 * int'(ir[31:30]) + 4 * int'(ir[24:19]);
        if (take) return target;
        return (pc + 1) % DEPTH;
    endfunction

    task automatic clear_inputs();
        start     = 1'b0;
        halt      = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        ir        = $urandom;
        psr       = 4'($urandom);
        mem_ready = 1'b1;
    endtask

    // Predicts the outputs after the coming edge, queues them, then steps one cycle.
    task automatic apply_stimulus();
        exp_t          e;
        logic [DW-1:0] w;
        e.reject = load_en && m_busy;
        if (!m_busy) begin
            if (load_en) begin
                cs_model[load_addr] = load_data;
            end else if (start) begin
                m_busy = 1'b1;
                m_pc   = 0;
            end
        end else begin
            w = cs_model[m_pc];
            if (!((w[RD_B] || w[WR_B]) && !mem_ready)) begin
                if (halt) begin
                    m_busy = 1'b0;
                    m_pc   = 0;
                end else begin
                    m_pc = next_pc(w, m_pc);
                end
            end
        end
        e.busy = m_busy;
        e.csar = AW'(m_pc);
        e.mir  = m_busy ? cs_model[m_pc] : '0;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [DW-1:0] data);
        clear_inputs();
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        apply_stimulus();
    endtask

    task automatic start_run();
        clear_inputs();
        start = 1'b1;
        apply_stimulus();
        start = 1'b0;
    endtask

    task automatic go_idle();
        clear_inputs();
        halt = 1'b1;
        for (int i = 0; i < 4 && m_busy; i++) apply_stimulus();
        halt = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest prediction once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("busy", 64'(busy), 64'(e.busy));
                check_val("csar", 64'(csar), 64'(e.csar));
                check_val("mir", 64'(mir), 64'(e.mir));
                check_val("load_reject", 64'(reject), 64'(e.reject));
            end
        end
    end

    initial begin
        clear_inputs();
        rst_n  = 1'b0;
        m_busy = 1'b0;
        m_pc   = 0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_csar", 64'(csar), 64'd0);
        check_val("reset_mir", 64'(mir), 64'd0);
        check_val("reset_reject", 64'(reject), 64'd0);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) load_word(a, rand_word());

        // Loop 0 -> 5 -> 6 -> 0, with a rejected write to address 5 mid-run.
        load_word(0, mk_word(0, 0, 6, 5));
        load_word(5, mk_word(0, 0, 0, 0));
        load_word(6, mk_word(0, 0, 6, 0));
        start_run();
        apply_stimulus();
        load_en   = 1'b1;
        load_addr = AW'(5);
        load_data = rand_word();
        apply_stimulus();
        clear_inputs();
        repeat (3) apply_stimulus();
        go_idle();

        // Flag and ir[13] conditional jumps, taken and not taken.
        for (int k = 1; k <= 5; k++) begin
            for (int f = 0; f < 2; f++) begin
                load_word(0, mk_word(0, 0, k, 'h640));
                start_run();
                psr    = (f != 0) ? 4'b0000 : 4'b1111;
                ir[13] = (f == 0);
                if (k <= 4) psr[4-k] = f[0];
                else ir[13] = f[0];
                apply_stimulus();
                go_idle();
            end
        end

        // Decode dispatch.
        for (int d = 0; d < 2; d++) begin
            load_word(0, mk_word(0, 0, 7, 0));
            start_run();
            ir[31:30] = 2'b10;
            ir[24:19] = (d == 0) ? 6'b000000 : 6'b010000;
            apply_stimulus();
            go_idle();
        end

        // CSAR+1 wraps from the top of the store.
        load_word(0, mk_word(0, 0, 6, 'h7FF));
        load_word('h7FF, mk_word(0, 0, 0, 0));
        start_run();
        repeat (2) apply_stimulus();
        go_idle();

        // Memory wait of three cycles, first advancing, then halting on ready.
        for (int h = 0; h < 2; h++) begin
            load_word(0, mk_word(1, 0, 0, 0));
            start_run();
            mem_ready = 1'b0;
            halt      = (h != 0);
            repeat (3) apply_stimulus();
            mem_ready = 1'b1;
            apply_stimulus();
            go_idle();
        end

        // Load and start together: the load wins, and the new word is read next cycle.
        clear_inputs();
        load_en   = 1'b1;
        start     = 1'b1;
        load_addr = '0;
        load_data = mk_word(0, 0, 0, 0);
        apply_stimulus();
        start_run();
        go_idle();

        // Asynchronous reset while stalled in a memory wait.
        load_word(0, mk_word(0, 1, 0, 0));
        start_run();
        mem_ready = 1'b0;
        repeat (2) apply_stimulus();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_busy = 1'b0;
        m_pc   = 0;
        check_val("async_busy", 64'(busy), 64'd0);
        check_val("async_csar", 64'(csar), 64'd0);
        check_val("async_mir", 64'(mir), 64'd0);
        check_val("async_reject", 64'(reject), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic.
        clear_inputs();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 19) == 0);
            load_en   = ($urandom_range(0, 19) == 0);
            load_addr = AW'($urandom_range(0, DEPTH - 1));
            load_data = rand_word();
            ir        = $urandom;
            psr       = 4'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus();
        end
        go_idle();

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
